packed_occupancy_grid: RTL and testbench
========================================

Name: packed_occupancy_grid

Overview:
- Parametrised successor to the single-bit-per-word occupancy grid: packs 2**DATA_WIDTH_LOG2 cells per memory word.
- Writes use read-modify-write; memory read latency is configurable.
- Adds a hardware clear sweep and a running occupied-cell count.
- Sits between the RRT collision checker / map loader and a single-port BRAM.

Parameters:
- GRID_WIDTH_LOG2, 6, log2 of grid width in cells.
- GRID_HEIGHT_LOG2, 6, log2 of grid height in cells.
- DATA_WIDTH_LOG2, 5, log2 of memory word width (cells per word); must be < GRID_WIDTH_LOG2+GRID_HEIGHT_LOG2.
- MEM_READ_LATENCY, 1, cycles from address presented to mem_rdata valid; >= 1.
- Derived (localparam): DATA_WIDTH = 2**DATA_WIDTH_LOG2; ADDR_WIDTH = GRID_WIDTH_LOG2+GRID_HEIGHT_LOG2-DATA_WIDTH_LOG2; CELLS_LOG2 = GRID_WIDTH_LOG2+GRID_HEIGHT_LOG2.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- cell_x_in  in  GRID_WIDTH_LOG2  cell column
- cell_y_in  in  GRID_HEIGHT_LOG2  cell row
- vld_in  in  1  request valid
- rdy  out  1  ready to accept a request
- we  in  1  1 = write request, 0 = read request
- w_occupied  in  1  value to write
- vld_out  out  1  one-cycle completion pulse
- r_occupied  out  1  cell value (read), or previous cell value (write)
- clear_start  in  1  start clear sweep
- clear_busy  out  1  sweep in progress
- occupied_count  out  CELLS_LOG2+1  number of occupied cells
- mem_addr  out  ADDR_WIDTH  memory word address
- mem_we  out  1  memory write enable
- mem_wdata  out  DATA_WIDTH  memory write data
- mem_rdata  in  DATA_WIDTH  memory read data

Behaviour:
- Addressing: idx = {cell_y_in, cell_x_in}; word = idx[CELLS_LOG2-1:DATA_WIDTH_LOG2]; bit = idx[DATA_WIDTH_LOG2-1:0].
- Reset (async): state IDLE; rdy=1, vld_out=0, r_occupied=0, clear_busy=0, occupied_count=0, mem_we=0, mem_addr=0, mem_wdata=0. Memory contents are not touched; software issues a clear after reset.
- Reset mid-operation: the operation is abandoned with no further memory write; mem_we falls immediately.
- All outputs are registered. rdy = (state==IDLE).
- Handshake:
  - A request is accepted at the edge where vld_in & rdy. x, y, we and w_occupied are captured there; inputs are don't-care otherwise.
  - clear_start has priority over vld_in in the same IDLE cycle; that request is not accepted.
  - clear_start outside IDLE is ignored.
- FSM states: IDLE, RD_WAIT, WR, CLEAR.
- IDLE -> RD_WAIT on accept: mem_addr=word, mem_we=0. A latency counter is loaded with MEM_READ_LATENCY.
- RD_WAIT: counter decrements each edge. On the edge it expires, mem_rdata is sampled and the old bit is extracted.
  - Read: r_occupied=old bit, vld_out=1 for one cycle, -> IDLE.
  - Write: merged word = rdata with the bit replaced, -> WR.
- Read latency: vld_out is set at edge accept+MEM_READ_LATENCY+1.
- WR (one cycle): mem_we=1, mem_wdata=merged, mem_addr held. On exit: r_occupied=old bit, vld_out=1, -> IDLE.
- Write latency: vld_out is set at edge accept+MEM_READ_LATENCY+2.
- occupied_count updates on the WR exit edge: +1 if old=0,new=1; -1 if old=1,new=0; unchanged otherwise. It never wraps; the full grid gives 2**CELLS_LOG2.
- CLEAR:
  - On entry: clear_busy=1, address counter=0.
  - Each cycle: mem_we=1, mem_wdata=0, mem_addr=counter; counter increments.
  - After address 2**ADDR_WIDTH-1 is written: -> IDLE, clear_busy=0, occupied_count=0.
  - Duration is exactly 2**ADDR_WIDTH cycles. vld_out is not pulsed.
- Back-to-back: a new request may be accepted in the cycle vld_out is high (rdy=1 there).
- Throughput: one read per MEM_READ_LATENCY+2 cycles; one write per MEM_READ_LATENCY+3 cycles.

Decomposition:
- Package occupancy_grid_pkg holds:
  - the state enum (IDLE, RD_WAIT, WR, CLEAR);
  - function cell_word(x,y) and function cell_bit(x,y), parametrised via module-computed widths or passed as arguments;
  - the localparam formulas above.
- No sub-module: the FSM, latency counter, sweep counter and bit merge fit in one module of roughly 200 lines.
- The bench wrapper pairs it with the existing bram.

Test Plan (defaults, MEM_READ_LATENCY=1):
- Write (x=5,y=2,1) -> idx 133, word 4 becomes 0x00000020; vld_out at accept+3; r_occupied=0; occupied_count=1.
- Read (5,2) -> r_occupied=1 at accept+2; read (6,2) -> 0; count stays 1.
- Rewrite (5,2)=1 -> r_occupied=1, count 1. Write (5,2)=0 -> r_occupied=1, count 0, word 4 becomes 0.
- Write (0,0)=1 and (63,63)=1 -> words 0 and 127 bit 0 / bit 31 set; count=2. clear_start -> clear_busy for exactly 128 cycles, rdy=0 throughout; then reads return 0 and count=0.
- clear_start and vld_in together in IDLE -> clear runs; request not accepted (rdy=0); the request re-presented after the sweep completes normally.
- Assert rst during WR of a write -> mem_we=0 in the same cycle; outputs at reset values; count=0; next request accepted normally.

Source files
------------

// File: rtl/packed_occupancy_grid_pkg.sv
// Shared types and address helpers for the packed occupancy grid.
// Widths are passed as arguments so one package serves every parametrisation.
package occupancy_grid_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_WAIT = 2'd1,
    WR      = 2'd2,
    CLEAR   = 2'd3
  } grid_state_e;

  function automatic int unsigned data_width(input int unsigned dw_log2);
    return 32'd1 << dw_log2;
  endfunction

  function automatic int unsigned cells_log2(input int unsigned gw_log2,
                                             input int unsigned gh_log2);
    return gw_log2 + gh_log2;
  endfunction

  function automatic int unsigned addr_width(input int unsigned gw_log2,
                                             input int unsigned gh_log2,
                                             input int unsigned dw_log2);
    return gw_log2 + gh_log2 - dw_log2;
  endfunction

  // Linear cell index is {y, x}; the upper bits select the word, the lower bits the cell.
  function automatic int unsigned cell_word(input int unsigned x, input int unsigned y,
                                            input int unsigned gw_log2,
                                            input int unsigned dw_log2);
    return ((y << gw_log2) | x) >> dw_log2;
  endfunction

  function automatic int unsigned cell_bit(input int unsigned x, input int unsigned y,
                                           input int unsigned gw_log2,
                                           input int unsigned dw_log2);
    return ((y << gw_log2) | x) & ((32'd1 << dw_log2) - 32'd1);
  endfunction

endpackage

// File: rtl/packed_occupancy_grid.sv
// Occupancy grid front end: packs cells into BRAM words, does read-modify-write
// cell updates, a full-memory clear sweep and a running occupied-cell count.
module packed_occupancy_grid
  import occupancy_grid_pkg::*;
#(
  parameter int unsigned GRID_WIDTH_LOG2  = 6,
  parameter int unsigned GRID_HEIGHT_LOG2 = 6,
  parameter int unsigned DATA_WIDTH_LOG2  = 5,
  parameter int unsigned MEM_READ_LATENCY = 1,
  localparam int unsigned DATA_WIDTH = data_width(DATA_WIDTH_LOG2),
  localparam int unsigned ADDR_WIDTH = addr_width(GRID_WIDTH_LOG2, GRID_HEIGHT_LOG2, DATA_WIDTH_LOG2),
  localparam int unsigned CELLS_LOG2 = cells_log2(GRID_WIDTH_LOG2, GRID_HEIGHT_LOG2)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [GRID_WIDTH_LOG2-1:0]  cell_x_in,
  input  logic [GRID_HEIGHT_LOG2-1:0] cell_y_in,
  input  logic                        vld_in,
  output logic                        rdy,
  input  logic                        we,
  input  logic                        w_occupied,
  output logic                        vld_out,
  output logic                        r_occupied,
  input  logic                        clear_start,
  output logic                        clear_busy,
  output logic [CELLS_LOG2:0]         occupied_count,
  output logic [ADDR_WIDTH-1:0]       mem_addr,
  output logic                        mem_we,
  output logic [DATA_WIDTH-1:0]       mem_wdata,
  input  logic [DATA_WIDTH-1:0]       mem_rdata
);

  localparam int unsigned LAT_W = $clog2(MEM_READ_LATENCY + 1);
  localparam logic [CELLS_LOG2:0] MAX_COUNT = {1'b1, {CELLS_LOG2{1'b0}}};

  grid_state_e                state_q, state_d;
  logic [LAT_W-1:0]           lat_q, lat_d;
  logic [DATA_WIDTH_LOG2-1:0] bit_q, bit_d;
  logic                       we_q, we_d;
  logic                       wval_q, wval_d;
  logic                       old_q, old_d;
  logic [ADDR_WIDTH-1:0]      mem_addr_q, mem_addr_d;
  logic                       mem_we_q, mem_we_d;
  logic [DATA_WIDTH-1:0]      mem_wdata_q, mem_wdata_d;
  logic                       vld_out_q, vld_out_d;
  logic                       r_occupied_q, r_occupied_d;
  logic                       clear_busy_q, clear_busy_d;
  logic [CELLS_LOG2:0]        count_q, count_d;
  logic                       rdy_q, rdy_d;
  logic [DATA_WIDTH-1:0]      merged;

  always_comb begin
    state_d      = state_q;
    lat_d        = lat_q;
    bit_d        = bit_q;
    we_d         = we_q;
    wval_d       = wval_q;
    old_d        = old_q;
    mem_addr_d   = mem_addr_q;
    mem_we_d     = mem_we_q;
    mem_wdata_d  = mem_wdata_q;
    vld_out_d    = 1'b0;
    r_occupied_d = r_occupied_q;
    clear_busy_d = clear_busy_q;
    count_d      = count_q;
    merged       = mem_rdata;
    merged[bit_q] = wval_q;

    case (state_q)
      IDLE: begin
        if (clear_start) begin
          state_d      = CLEAR;
          mem_addr_d   = '0;
          mem_we_d     = 1'b1;
          mem_wdata_d  = '0;
          clear_busy_d = 1'b1;
        end else if (vld_in) begin
          state_d    = RD_WAIT;
          mem_addr_d = ADDR_WIDTH'(cell_word(32'(cell_x_in), 32'(cell_y_in),
                                             GRID_WIDTH_LOG2, DATA_WIDTH_LOG2));
          bit_d      = DATA_WIDTH_LOG2'(cell_bit(32'(cell_x_in), 32'(cell_y_in),
                                                 GRID_WIDTH_LOG2, DATA_WIDTH_LOG2));
          mem_we_d   = 1'b0;
          lat_d      = LAT_W'(MEM_READ_LATENCY);
          we_d       = we;
          wval_d     = w_occupied;
        end
      end
      RD_WAIT: begin
        // Counter reaching zero marks the edge at which mem_rdata is valid.
        if (lat_q != '0) begin
          lat_d = lat_q - LAT_W'(1);
        end else begin
          old_d = mem_rdata[bit_q];
          if (we_q) begin
            state_d     = WR;
            mem_we_d    = 1'b1;
            mem_wdata_d = merged;
          end else begin
            state_d      = IDLE;
            r_occupied_d = mem_rdata[bit_q];
            vld_out_d    = 1'b1;
          end
        end
      end
      WR: begin
        state_d      = IDLE;
        mem_we_d     = 1'b0;
        r_occupied_d = old_q;
        vld_out_d    = 1'b1;
        if (!old_q && wval_q && count_q != MAX_COUNT) begin
          count_d = count_q + 1'b1;
        end else if (old_q && !wval_q && count_q != '0) begin
          count_d = count_q - 1'b1;
        end
      end
      CLEAR: begin
        if (mem_addr_q == '1) begin
          state_d      = IDLE;
          mem_we_d     = 1'b0;
          clear_busy_d = 1'b0;
          count_d      = '0;
        end else begin
          mem_addr_d = mem_addr_q + ADDR_WIDTH'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    rdy_d = (state_d == IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      lat_q        <= '0;
      bit_q        <= '0;
      we_q         <= 1'b0;
      wval_q       <= 1'b0;
      old_q        <= 1'b0;
      mem_addr_q   <= '0;
      mem_we_q     <= 1'b0;
      mem_wdata_q  <= '0;
      vld_out_q    <= 1'b0;
      r_occupied_q <= 1'b0;
      clear_busy_q <= 1'b0;
      count_q      <= '0;
      rdy_q        <= 1'b1;
    end else begin
      state_q      <= state_d;
      lat_q        <= lat_d;
      bit_q        <= bit_d;
      we_q         <= we_d;
      wval_q       <= wval_d;
      old_q        <= old_d;
      mem_addr_q   <= mem_addr_d;
      mem_we_q     <= mem_we_d;
      mem_wdata_q  <= mem_wdata_d;
      vld_out_q    <= vld_out_d;
      r_occupied_q <= r_occupied_d;
      clear_busy_q <= clear_busy_d;
      count_q      <= count_d;
      rdy_q        <= rdy_d;
    end
  end

  assign rdy            = rdy_q;
  assign vld_out        = vld_out_q;
  assign r_occupied     = r_occupied_q;
  assign clear_busy     = clear_busy_q;
  assign occupied_count = count_q;
  assign mem_addr       = mem_addr_q;
  assign mem_we         = mem_we_q;
  assign mem_wdata      = mem_wdata_q;

endmodule

// File: tb/tb_packed_occupancy_grid.sv
// Directed bench for packed_occupancy_grid paired with a 1-cycle-latency BRAM model.
module tb_packed_occupancy_grid;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [5:0]  cell_x_in = '0;
  logic [5:0]  cell_y_in = '0;
  logic        vld_in = 1'b0;
  logic        rdy;
  logic        we = 1'b0;
  logic        w_occupied = 1'b0;
  logic        vld_out;
  logic        r_occupied;
  logic        clear_start = 1'b0;
  logic        clear_busy;
  logic [12:0] occupied_count;
  logic [6:0]  mem_addr;
  logic        mem_we;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  logic [31:0] bram [0:127];

  int n_pass   = 0;
  int n_checks = 0;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_we) bram[mem_addr] <= mem_wdata;
    mem_rdata <= bram[mem_addr];
  end

  packed_occupancy_grid #(
    .GRID_WIDTH_LOG2 (6),
    .GRID_HEIGHT_LOG2(6),
    .DATA_WIDTH_LOG2 (5),
    .MEM_READ_LATENCY(1)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .cell_x_in     (cell_x_in),
    .cell_y_in     (cell_y_in),
    .vld_in        (vld_in),
    .rdy           (rdy),
    .we            (we),
    .w_occupied    (w_occupied),
    .vld_out       (vld_out),
    .r_occupied    (r_occupied),
    .clear_start   (clear_start),
    .clear_busy    (clear_busy),
    .occupied_count(occupied_count),
    .mem_addr      (mem_addr),
    .mem_we        (mem_we),
    .mem_wdata     (mem_wdata),
    .mem_rdata     (mem_rdata)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Issue one request and follow it to its completion pulse.
  task automatic run_req(input string tag, input int x, input int y, input logic wr,
                         input logic wv, input int exp_lat, input logic exp_r,
                         input int exp_cnt);
    int n;
    chk({tag, "_rdy"}, 32'(rdy), 32'd1);
    cell_x_in  = 6'(x);
    cell_y_in  = 6'(y);
    we         = wr;
    w_occupied = wv;
    vld_in     = 1'b1;
    tick();
    vld_in    = 1'b0;
    cell_x_in = '0;
    cell_y_in = '0;
    n = 0;
    while (!vld_out && n < 20) begin
      tick();
      n++;
    end
    chk({tag, "_lat"}, 32'(n), 32'(exp_lat));
    chk({tag, "_r"}, 32'(r_occupied), 32'(exp_r));
    chk({tag, "_cnt"}, 32'(occupied_count), 32'(exp_cnt));
    chk({tag, "_rdy_at_vld"}, 32'(rdy), 32'd1);
  endtask

  // Count cycles with clear_busy high; rdy and vld_out must stay low throughout.
  task automatic run_sweep(input string tag);
    int  n;
    logic bad;
    n   = 0;
    bad = 1'b0;
    while (clear_busy && n < 300) begin
      if (rdy || vld_out) bad = 1'b1;
      n++;
      tick();
    end
    chk({tag, "_cycles"}, 32'(n), 32'd128);
    chk({tag, "_rdy_low"}, 32'(bad), 32'd0);
    chk({tag, "_cnt"}, 32'(occupied_count), 32'd0);
    chk({tag, "_rdy_after"}, 32'(rdy), 32'd1);
  endtask

  initial begin
    // Reset values
    #12;
    chk("rst_rdy", 32'(rdy), 32'd1);
    chk("rst_vld", 32'(vld_out), 32'd0);
    chk("rst_r", 32'(r_occupied), 32'd0);
    chk("rst_busy", 32'(clear_busy), 32'd0);
    chk("rst_cnt", 32'(occupied_count), 32'd0);
    chk("rst_we", 32'(mem_we), 32'd0);
    chk("rst_addr", 32'(mem_addr), 32'd0);
    chk("rst_wdata", mem_wdata, 32'd0);
    rst = 1'b0;
    tick();

    // Initial clear
    clear_start = 1'b1;
    tick();
    clear_start = 1'b0;
    chk("clr0_busy", 32'(clear_busy), 32'd1);
    chk("clr0_we", 32'(mem_we), 32'd1);
    chk("clr0_addr", 32'(mem_addr), 32'd0);
    run_sweep("clr0");

    // Single cell write / read
    run_req("wr52", 5, 2, 1'b1, 1'b1, 3, 1'b0, 1);
    chk("wr52_word4", bram[4], 32'h0000_0020);
    run_req("rd52", 5, 2, 1'b0, 1'b0, 2, 1'b1, 1);
    run_req("rd62", 6, 2, 1'b0, 1'b0, 2, 1'b0, 1);
    run_req("rewr52", 5, 2, 1'b1, 1'b1, 3, 1'b1, 1);
    run_req("wr52_0", 5, 2, 1'b1, 1'b0, 3, 1'b1, 0);
    chk("wr52_0_word4", bram[4], 32'h0000_0000);

    // Grid corners
    run_req("wr00", 0, 0, 1'b1, 1'b1, 3, 1'b0, 1);
    run_req("wr6363", 63, 63, 1'b1, 1'b1, 3, 1'b0, 2);
    chk("word0", bram[0], 32'h0000_0001);
    chk("word127", bram[127], 32'h8000_0000);

    // Clear sweep wipes everything
    clear_start = 1'b1;
    tick();
    clear_start = 1'b0;
    run_sweep("clr1");
    chk("clr1_word127", bram[127], 32'h0000_0000);
    run_req("rd00", 0, 0, 1'b0, 1'b0, 2, 1'b0, 0);
    run_req("rd6363", 63, 63, 1'b0, 1'b0, 2, 1'b0, 0);

    // clear_start beats vld_in
    clear_start = 1'b1;
    vld_in      = 1'b1;
    we          = 1'b1;
    w_occupied  = 1'b1;
    cell_x_in   = 6'd7;
    cell_y_in   = 6'd1;
    tick();
    clear_start = 1'b0;
    vld_in      = 1'b0;
    chk("prio_busy", 32'(clear_busy), 32'd1);
    chk("prio_rdy", 32'(rdy), 32'd0);
    chk("prio_addr", 32'(mem_addr), 32'd0);
    run_sweep("prio");
    run_req("wr71", 7, 1, 1'b1, 1'b1, 3, 1'b0, 1);
    chk("wr71_word2", bram[2], 32'h0000_0080);

    // Reset in the WR cycle abandons the write
    cell_x_in  = 6'd9;
    cell_y_in  = 6'd3;
    we         = 1'b1;
    w_occupied = 1'b1;
    vld_in     = 1'b1;
    tick();
    vld_in = 1'b0;
    tick();
    tick();
    chk("wr93_in_wr", 32'(mem_we), 32'd1);
    rst = 1'b1;
    #1;
    chk("mid_rst_we", 32'(mem_we), 32'd0);
    chk("mid_rst_rdy", 32'(rdy), 32'd1);
    chk("mid_rst_cnt", 32'(occupied_count), 32'd0);
    chk("mid_rst_addr", 32'(mem_addr), 32'd0);
    chk("mid_rst_vld", 32'(vld_out), 32'd0);
    #3;
    rst = 1'b0;
    tick();
    chk("mid_rst_word6", bram[6], 32'h0000_0000);
    run_req("rd93", 9, 3, 1'b0, 1'b0, 2, 1'b0, 0);
    run_req("wr93", 9, 3, 1'b1, 1'b1, 3, 1'b0, 1);
    chk("wr93_word6", bram[6], 32'h0000_0200);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
